// File: rtl/rate_change_cfg_ctrl_if.sv
// Reconfiguration request channel of the rate-change config controller:
// a valid/ready handshake carrying the new N, M and config word.
interface rate_change_cfg_ctrl_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_n;
  logic [15:0] cfg_m;
  logic [31:0] cfg_word;

  modport master (
    output cfg_valid,
    output cfg_n,
    output cfg_m,
    output cfg_word,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_n,
    input  cfg_m,
    input  cfg_word,
    output cfg_ready
  );
endinterface

// File: rtl/rate_change_cfg_ctrl.sv
// Reconfiguration sequencer for a rate-change block: drains the packet in flight,
// clears the block, writes N, M and config over the settings bus, then settles.
module rate_change_cfg_ctrl #(
  parameter int SR_N_ADDR      = 0,
  parameter int SR_M_ADDR      = 1,
  parameter int SR_CONFIG_ADDR = 2,
  parameter int MAX_N          = 16,
  parameter int MAX_M          = 16,
  parameter int CLEAR_CYCLES   = 2,
  parameter int SETTLE_CYCLES  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  rate_change_cfg_ctrl_if.slave        cfg,
  input  logic                         in_tvalid,
  input  logic                         in_tready,
  input  logic                         in_tlast,
  output logic                         hold_in,
  output logic                         clear,
  output logic                         set_stb,
  output logic [7:0]                   set_addr,
  output logic [31:0]                  set_data,
  output logic                         busy,
  output logic                         cfg_done,
  output logic                         cfg_error
);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    CLEAR,
    WR_N,
    WR_M,
    WR_CFG,
    SETTLE
  } state_t;

  localparam logic [15:0] MAX_N_W     = 16'(MAX_N);
  localparam logic [15:0] MAX_M_W     = 16'(MAX_M);
  localparam logic [7:0]  N_ADDR      = 8'(SR_N_ADDR);
  localparam logic [7:0]  M_ADDR      = 8'(SR_M_ADDR);
  localparam logic [7:0]  CFG_ADDR    = 8'(SR_CONFIG_ADDR);
  localparam logic [7:0]  CLEAR_LAST  = 8'(CLEAR_CYCLES - 1);
  localparam logic [7:0]  SETTLE_LAST = 8'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);

  state_t      state;
  logic        mid_pkt;
  logic        mid_pkt_next;
  logic        beat;
  logic        handshake;
  logic        cfg_legal;
  logic [7:0]  cnt;
  logic [15:0] n_q;
  logic [15:0] m_q;
  logic [31:0] word_q;

  assign cfg.cfg_ready = (state == IDLE) & ~reset;
  assign handshake     = cfg.cfg_valid & cfg.cfg_ready;
  assign cfg_legal     = (cfg.cfg_n != 16'd0) && (cfg.cfg_n <= MAX_N_W) &&
                         (cfg.cfg_m != 16'd0) && (cfg.cfg_m <= MAX_M_W);

  // Once draining starts, only the remainder of the current packet may pass.
  assign hold_in      = (state != IDLE) & ~((state == DRAIN) & mid_pkt);
  assign busy         = (state != IDLE);
  assign beat         = in_tvalid & in_tready & ~hold_in;
  assign mid_pkt_next = beat ? ~in_tlast : mid_pkt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mid_pkt   <= 1'b0;
      cnt       <= 8'd0;
      n_q       <= 16'd0;
      m_q       <= 16'd0;
      word_q    <= 32'd0;
      clear     <= 1'b0;
      set_stb   <= 1'b0;
      set_addr  <= 8'd0;
      set_data  <= 32'd0;
      cfg_done  <= 1'b0;
      cfg_error <= 1'b0;
    end else begin
      mid_pkt   <= mid_pkt_next;
      clear     <= 1'b0;
      set_stb   <= 1'b0;
      set_addr  <= 8'd0;
      set_data  <= 32'd0;
      cfg_done  <= 1'b0;
      cfg_error <= 1'b0;
      case (state)
        IDLE: begin
          if (handshake) begin
            if (cfg_legal) begin
              n_q    <= cfg.cfg_n;
              m_q    <= cfg.cfg_m;
              word_q <= cfg.cfg_word;
              state  <= DRAIN;
            end else begin
              cfg_error <= 1'b1;
            end
          end
        end
        // Leave as soon as the tlast beat of the open packet has gone through.
        DRAIN: begin
          if (!mid_pkt_next) begin
            state <= CLEAR;
            clear <= 1'b1;
            cnt   <= 8'd0;
          end
        end
        CLEAR: begin
          if (cnt == CLEAR_LAST) begin
            state    <= WR_N;
            cnt      <= 8'd0;
            set_stb  <= 1'b1;
            set_addr <= N_ADDR;
            set_data <= {16'd0, n_q};
          end else begin
            cnt   <= cnt + 8'd1;
            clear <= 1'b1;
          end
        end
        WR_N: begin
          state    <= WR_M;
          set_stb  <= 1'b1;
          set_addr <= M_ADDR;
          set_data <= {16'd0, m_q};
        end
        WR_M: begin
          state    <= WR_CFG;
          set_stb  <= 1'b1;
          set_addr <= CFG_ADDR;
          set_data <= word_q;
        end
        WR_CFG: begin
          if (SETTLE_CYCLES == 0) begin
            state    <= IDLE;
            cfg_done <= 1'b1;
          end else begin
            state <= SETTLE;
            cnt   <= 8'd0;
          end
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            cfg_done <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rate_change_cfg_ctrl.sv
// Directed bench for rate_change_cfg_ctrl: a table of requests plus hand-built
// sequences for mid-packet drain, back-to-back requests and reset mid-sequence.
module tb_rate_change_cfg_ctrl;

  typedef struct {
    logic [15:0] n;
    logic [15:0] m;
    logic [31:0] word;
    logic        exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic in_tvalid, in_tready, in_tlast;
  logic hold_in, clear, set_stb, busy, cfg_done, cfg_error;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic hold_in_s0, clear_s0, set_stb_s0, busy_s0, cfg_done_s0, cfg_error_s0;
  logic [7:0]  set_addr_s0;
  logic [31:0] set_data_s0;

  int vec_count  = 0;
  int miss_count = 0;
  vec_t vecs[8];

  always #5 clk = ~clk;

  rate_change_cfg_ctrl_if cfg_bus ();
  rate_change_cfg_ctrl_if cfg_bus0 ();

  rate_change_cfg_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .cfg       (cfg_bus),
    .in_tvalid (in_tvalid),
    .in_tready (in_tready),
    .in_tlast  (in_tlast),
    .hold_in   (hold_in),
    .clear     (clear),
    .set_stb   (set_stb),
    .set_addr  (set_addr),
    .set_data  (set_data),
    .busy      (busy),
    .cfg_done  (cfg_done),
    .cfg_error (cfg_error)
  );

  // Zero-settle build, driven only by the request table with an idle stream.
  rate_change_cfg_ctrl #(.SETTLE_CYCLES(0)) dut_s0 (
    .clk       (clk),
    .reset     (reset),
    .cfg       (cfg_bus0),
    .in_tvalid (1'b0),
    .in_tready (1'b0),
    .in_tlast  (1'b0),
    .hold_in   (hold_in_s0),
    .clear     (clear_s0),
    .set_stb   (set_stb_s0),
    .set_addr  (set_addr_s0),
    .set_data  (set_data_s0),
    .busy      (busy_s0),
    .cfg_done  (cfg_done_s0),
    .cfg_error (cfg_error_s0)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] n, input logic [15:0] m,
                               input logic [31:0] w, input logic both);
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_n     = n;
    cfg_bus.cfg_m     = m;
    cfg_bus.cfg_word  = w;
    if (both) begin
      cfg_bus0.cfg_valid = 1'b1;
      cfg_bus0.cfg_n     = n;
      cfg_bus0.cfg_m     = m;
      cfg_bus0.cfg_word  = w;
    end
  endtask

  task automatic releaseReq();
    cfg_bus.cfg_valid  = 1'b0;
    cfg_bus0.cfg_valid = 1'b0;
  endtask

  // Expected outputs of the default build, rel cycles after the accept cycle
  // with a one-cycle drain: clear 2-3, writes 4-6, settle 7-8, done at 9.
  task automatic checkCycle(input string tag, input int rel, input logic [15:0] n,
                            input logic [15:0] m, input logic [31:0] w);
    logic [7:0]  e_addr;
    logic [31:0] e_data;
    e_addr = (rel == 5) ? 8'd1 : (rel == 6) ? 8'd2 : 8'd0;
    e_data = (rel == 4) ? {16'd0, n} : (rel == 5) ? {16'd0, m} : (rel == 6) ? w : 32'd0;
    checkOutput($sformatf("%s r%0d clear", tag, rel), 32'(clear), 32'(rel == 2 || rel == 3));
    checkOutput($sformatf("%s r%0d set_stb", tag, rel), 32'(set_stb), 32'(rel >= 4 && rel <= 6));
    checkOutput($sformatf("%s r%0d set_addr", tag, rel), 32'(set_addr), 32'(e_addr));
    checkOutput($sformatf("%s r%0d set_data", tag, rel), set_data, e_data);
    checkOutput($sformatf("%s r%0d cfg_done", tag, rel), 32'(cfg_done), 32'(rel == 9));
    checkOutput($sformatf("%s r%0d busy", tag, rel), 32'(busy), 32'(rel <= 8));
    checkOutput($sformatf("%s r%0d hold_in", tag, rel), 32'(hold_in), 32'(rel <= 8));
    checkOutput($sformatf("%s r%0d cfg_ready", tag, rel), 32'(cfg_bus.cfg_ready), 32'(rel > 8));
    checkOutput($sformatf("%s r%0d cfg_error", tag, rel), 32'(cfg_error), 32'd0);
  endtask

  task automatic runLegal(input string tag, input logic [15:0] n, input logic [15:0] m,
                          input logic [31:0] w, input logic both);
    applyStimulus(n, m, w, both);
    checkOutput({tag, " ready at request"}, 32'(cfg_bus.cfg_ready), 32'd1);
    tick();
    releaseReq();
    for (int c = 1; c <= 10; c++) begin
      checkCycle(tag, c, n, m, w);
      if (both) begin
        checkOutput($sformatf("%s r%0d s0 cfg_done", tag, c), 32'(cfg_done_s0), 32'(c == 7));
        checkOutput($sformatf("%s r%0d s0 busy", tag, c), 32'(busy_s0), 32'(c <= 6));
      end
      tick();
    end
  endtask

  task automatic runIllegal(input string tag, input logic [15:0] n, input logic [15:0] m,
                            input logic [31:0] w);
    applyStimulus(n, m, w, 1'b1);
    tick();
    releaseReq();
    checkOutput({tag, " cfg_error pulse"}, 32'(cfg_error), 32'd1);
    checkOutput({tag, " s0 cfg_error pulse"}, 32'(cfg_error_s0), 32'd1);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    tick();
    for (int c = 2; c <= 4; c++) begin
      checkOutput($sformatf("%s r%0d cfg_error", tag, c), 32'(cfg_error), 32'd0);
      checkOutput($sformatf("%s r%0d set_stb", tag, c), 32'(set_stb), 32'd0);
      checkOutput($sformatf("%s r%0d clear", tag, c), 32'(clear), 32'd0);
      checkOutput($sformatf("%s r%0d busy", tag, c), 32'(busy), 32'd0);
      tick();
    end
  endtask

  initial begin
    vecs[0] = '{16'd4,      16'd3,  32'h0000_0001, 1'b0};
    vecs[1] = '{16'd0,      16'd5,  32'h0000_0055, 1'b1};
    vecs[2] = '{16'd5,      16'd17, 32'h0000_0066, 1'b1};
    vecs[3] = '{16'd16,     16'd16, 32'hDEAD_BEEF, 1'b0};
    vecs[4] = '{16'd1,      16'd1,  32'h0000_0000, 1'b0};
    vecs[5] = '{16'd17,     16'd16, 32'h0000_0000, 1'b1};
    vecs[6] = '{16'd16,     16'd0,  32'h0000_0001, 1'b1};
    vecs[7] = '{16'hFFFF,   16'd2,  32'h0000_0000, 1'b1};

    reset     = 1'b1;
    in_tvalid = 1'b0;
    in_tready = 1'b0;
    in_tlast  = 1'b0;
    releaseReq();
    cfg_bus.cfg_n  = 16'd0;  cfg_bus.cfg_m  = 16'd0;  cfg_bus.cfg_word  = 32'd0;
    cfg_bus0.cfg_n = 16'd0;  cfg_bus0.cfg_m = 16'd0;  cfg_bus0.cfg_word = 32'd0;

    tick();
    checkOutput("reset cfg_ready", 32'(cfg_bus.cfg_ready), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset hold_in", 32'(hold_in), 32'd0);
    checkOutput("reset clear", 32'(clear), 32'd0);
    checkOutput("reset set_stb", 32'(set_stb), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();
    checkOutput("post-reset cfg_ready", 32'(cfg_bus.cfg_ready), 32'd1);
    checkOutput("post-reset busy", 32'(busy), 32'd0);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].exp_err)
        runIllegal($sformatf("vec%0d", i), vecs[i].n, vecs[i].m, vecs[i].word);
      else
        runLegal($sformatf("vec%0d", i), vecs[i].n, vecs[i].m, vecs[i].word, 1'b1);
    end

    // Request lands on beat 3 of a 16-beat packet; beats 4-16 must still pass.
    in_tvalid = 1'b1;
    in_tready = 1'b1;
    in_tlast  = 1'b0;
    tick();
    tick();
    applyStimulus(16'd5, 16'd4, 32'h77, 1'b0);
    tick();
    releaseReq();
    for (int c = 1; c <= 21; c++) begin
      in_tvalid = (c <= 20);
      in_tready = (c <= 20);
      in_tlast  = (c == 13);
      if (c <= 13) begin
        checkOutput($sformatf("midpkt c%0d hold_in", c), 32'(hold_in), 32'd0);
        checkOutput($sformatf("midpkt c%0d clear", c), 32'(clear), 32'd0);
        checkOutput($sformatf("midpkt c%0d busy", c), 32'(busy), 32'd1);
      end else begin
        checkCycle("midpkt", c - 12, 16'd5, 16'd4, 32'h77);
      end
      tick();
    end
    in_tvalid = 1'b0;
    in_tready = 1'b0;
    in_tlast  = 1'b0;
    runLegal("after_midpkt", 16'd2, 16'd3, 32'h23, 1'b0);

    // cfg_valid held high with changing values while the first sequence runs.
    applyStimulus(16'd3, 16'd2, 32'hA, 1'b0);
    tick();
    for (int c = 1; c <= 19; c++) begin
      if (c <= 8) begin
        cfg_bus.cfg_n    = 16'(c);
        cfg_bus.cfg_m    = 16'(c + 8);
        cfg_bus.cfg_word = 32'(c * 17);
      end else if (c == 9) begin
        cfg_bus.cfg_n    = 16'd6;
        cfg_bus.cfg_m    = 16'd5;
        cfg_bus.cfg_word = 32'hB;
      end else begin
        cfg_bus.cfg_valid = 1'b0;
      end
      if (c <= 9)
        checkCycle("b2b_first", c, 16'd3, 16'd2, 32'hA);
      else
        checkCycle("b2b_second", c - 9, 16'd6, 16'd5, 32'hB);
      tick();
    end

    // Reset while the M write is on the bus: config write must never follow.
    applyStimulus(16'd5, 16'd6, 32'hC, 1'b0);
    tick();
    releaseReq();
    for (int c = 1; c <= 5; c++) begin
      checkCycle("rst_seq", c, 16'd5, 16'd6, 32'hC);
      if (c < 5) tick();
    end
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_mid set_stb", 32'(set_stb), 32'd0);
    checkOutput("rst_mid set_addr", 32'(set_addr), 32'd0);
    checkOutput("rst_mid set_data", set_data, 32'd0);
    checkOutput("rst_mid clear", 32'(clear), 32'd0);
    checkOutput("rst_mid busy", 32'(busy), 32'd0);
    checkOutput("rst_mid hold_in", 32'(hold_in), 32'd0);
    checkOutput("rst_mid cfg_done", 32'(cfg_done), 32'd0);
    checkOutput("rst_mid cfg_error", 32'(cfg_error), 32'd0);
    checkOutput("rst_mid cfg_ready", 32'(cfg_bus.cfg_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    for (int c = 0; c < 10; c++) begin
      checkOutput($sformatf("rst_after c%0d set_stb", c), 32'(set_stb), 32'd0);
      checkOutput($sformatf("rst_after c%0d busy", c), 32'(busy), 32'd0);
      tick();
    end
    runLegal("after_rst", 16'd2, 16'd2, 32'h22, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule

// File: doc/rate_change_cfg_ctrl.md
RATE_CHANGE_CFG_CTRL -- requirements
Module: rate_change_cfg_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- SR_N_ADDR, 0, settings address of the decimation (N) register.
- SR_M_ADDR, 1, settings address of the interpolation (M) register.
- SR_CONFIG_ADDR, 2, settings address of the config register.
- MAX_N, 16, largest legal N.
- MAX_M, 16, largest legal M.
- CLEAR_CYCLES, 2, number of cycles clear is held (legal range 1-255).
- SETTLE_CYCLES, 2, number of wait cycles after the last write (legal range 0-255).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, the single clock.
- reset, in, 1, asynchronous active-high reset.
- cfg_valid, in, 1, reconfiguration request.
- cfg_ready, out, 1, request accepted when high together with cfg_valid.
- cfg_n, in, 16, requested N.
- cfg_m, in, 16, requested M.
- cfg_word, in, 32, data for SR_CONFIG_ADDR.
- in_tvalid, in, 1, monitored rate-change input valid.
- in_tready, in, 1, monitored rate-change input ready.
- in_tlast, in, 1, monitored rate-change input last.
- hold_in, out, 1, when high the integrator forces the rate-change input tvalid and tready low.
- clear, out, 1, clear to the rate-change block and to user logic.
- set_stb, out, 1, settings strobe.
- set_addr, out, 8, settings address.
- set_data, out, 32, settings data.
- busy, out, 1, sequence in progress.
- cfg_done, out, 1, one-cycle pulse when a sequence completes.
- cfg_error, out, 1, one-cycle pulse when a request is rejected.

Function
REQ-003 The FSM SHALL have exactly these states: IDLE, DRAIN, CLEAR, WR_N, WR_M, WR_CFG, SETTLE. The state register SHALL use clk and reset.
REQ-004 cfg_ready SHALL be 1 only in IDLE. An input handshake is cfg_valid & cfg_ready.
REQ-005 On a handshake where 1<=cfg_n<=MAX_N and 1<=cfg_m<=MAX_M, the block SHALL latch cfg_n, cfg_m and cfg_word and go to DRAIN on the next cycle.
REQ-006 On a handshake with an illegal N or M, the block SHALL pulse cfg_error on the next cycle, stay in IDLE, and issue no write and no clear.
REQ-007 The mid_pkt flag SHALL behave as follows:
- set on in_tvalid & in_tready & ~in_tlast;
- cleared on in_tvalid & in_tready & in_tlast;
- tracked in every state.
REQ-008 hold_in SHALL be combinational: (state != IDLE) & ~(state == DRAIN & mid_pkt). No new packet can therefore start once draining begins.
REQ-009 DRAIN SHALL go to CLEAR on the first cycle mid_pkt is 0. DRAIN may last indefinitely, with no timeout.
REQ-010 In CLEAR, clear SHALL be 1 for exactly CLEAR_CYCLES consecutive cycles, counted by an internal counter, then the FSM goes to WR_N.
REQ-011 WR_N, WR_M and WR_CFG SHALL each last exactly one cycle with set_stb=1. The writes, in this order, are:
- WR_N: set_addr=SR_N_ADDR, set_data = latched N zero-extended to 32 bits.
- WR_M: set_addr=SR_M_ADDR, set_data = latched M zero-extended to 32 bits.
- WR_CFG: set_addr=SR_CONFIG_ADDR, set_data = latched cfg_word.
REQ-012 SETTLE SHALL last SETTLE_CYCLES cycles, or 0 cycles if the parameter is 0. On exit the FSM goes to IDLE and cfg_done pulses for 1 cycle, coincident with the first IDLE cycle.
REQ-013 Outside the write states, set_stb, set_addr and set_data SHALL be 0. Outside CLEAR, clear SHALL be 0.
REQ-014 busy SHALL be (state != IDLE).
REQ-015 With mid_pkt=0 at accept, cfg_done SHALL occur 1+1+CLEAR_CYCLES+3+SETTLE_CYCLES cycles after the accept edge, which is 9 with the defaults.
REQ-016 cfg_valid arriving while busy SHALL be held off (cfg_ready=0) and SHALL NOT alter the latched values.
REQ-017 Beats on in_* while hold_in=1 are an integration error and SHALL be ignored by mid_pkt.

Reset
REQ-018 Asserting reset SHALL immediately force: state=IDLE, mid_pkt=0, all counters 0, and clear, set_stb, set_addr, set_data, cfg_done, cfg_error, busy and hold_in all 0. cfg_ready goes to 1 after reset deasserts.
REQ-019 Reset mid-sequence SHALL abandon the sequence with no further writes. Writes already issued remain in effect.

Verification
REQ-020 Idle accept: cfg_n=4, cfg_m=3, cfg_word=0x1, mid_pkt=0 -> clear high 2 cycles, then writes (0,4), (1,3), (2,1) on consecutive cycles, cfg_done 9 cycles after accept.
REQ-021 Mid-packet: accept during beat 3 of a 16-beat packet -> hold_in stays 0 until the tlast beat handshakes, clear starts the cycle after, and no new packet beat is accepted before cfg_done.
REQ-022 Illegal: cfg_n=0, then cfg_m=17 -> cfg_error pulses once each, set_stb and clear stay 0.
REQ-023 Back-to-back: cfg_valid held with values changing while busy -> second request accepted only on the first IDLE cycle after cfg_done, and the first sequence writes its originally latched values.
REQ-024 Reset during WR_M: assert reset -> outputs 0 immediately, SR_CONFIG_ADDR never written, and a subsequent request (2,2) completes normally.
REQ-025 Boundaries: MAX_N=16, MAX_M=16 accepted; SETTLE_CYCLES=0 build gives cfg_done 7 cycles after accept.
